// File: rtl/map_pkg.sv
// Map geometry, tile codes and row bit-placement shared by the map writer,
// location controllers and tile decode.
package map_pkg;

    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;
    localparam int TILE_W   = 4;
    localparam int ROW_W    = 160;

    typedef enum logic [3:0] {
        TILE_EMPTY  = 4'h0,
        TILE_WALL   = 4'h1,
        TILE_DOT    = 4'h2,
        TILE_POWER  = 4'h3,
        TILE_PACMAN = 4'h4,
        TILE_GHOST  = 4'h5,
        TILE_DOOR   = 4'h6
    } tile_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_WRITE
    } wr_state_t;

    // Column 0 sits at the MSB so the display decode can scan left to right.
    function automatic logic [7:0] tile_lsb(input logic [5:0] col);
        return 8'(ROW_W - TILE_W) - {col, 2'b00};
    endfunction

endpackage

// File: rtl/map_write_arbiter_if.sv
// Requester handshake plus map RAM port-B bus; slave is the arbiter side,
// master is the requester/RAM environment.
interface map_write_arbiter_if #(
    parameter int N_REQ = 3
);
    import map_pkg::*;

    logic                    enable;
    logic [N_REQ-1:0]        req;
    logic [5*N_REQ-1:0]      req_row;
    logic [6*N_REQ-1:0]      req_col;
    logic [TILE_W*N_REQ-1:0] req_tile;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic [TILE_W-1:0]       old_tile;
    logic                    err;
    logic                    busy;
    logic [4:0]              ram_addr;
    logic                    ram_wren;
    logic [ROW_W-1:0]        ram_wrdata;
    logic [ROW_W-1:0]        ram_rddata;

    modport slave (
        input  enable, req, req_row, req_col, req_tile, ram_rddata,
        output grant, done, old_tile, err, busy, ram_addr, ram_wren, ram_wrdata
    );

    modport master (
        output enable, req, req_row, req_col, req_tile, ram_rddata,
        input  grant, done, old_tile, err, busy, ram_addr, ram_wren, ram_wrdata
    );

endinterface

// File: rtl/map_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_served wins.
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_served_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int cand;
        cand    = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_served_i) + k) % N_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/map_write_arbiter.sv
// Read-modify-write sequencer sharing map RAM port B among N_REQ requesters.
//   state      | meaning
//   ST_IDLE    | waiting for an enabled request
//   ST_READ    | row address held for RD_LAT cycles
//   ST_CAPTURE | read word valid; merge new tile, extract old tile
//   ST_WRITE   | write-back cycle; done/err/old_tile presented
module map_write_arbiter #(
    parameter int N_REQ    = 3,
    parameter int RD_LAT   = 1,
    parameter int MAP_COLS = map_pkg::MAP_COLS,
    parameter int MAP_ROWS = map_pkg::MAP_ROWS
) (
    input logic                CLOCK_50,
    input logic                reset,
    map_write_arbiter_if.slave bus
);
    import map_pkg::*;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [5:0] COL_LIM = 6'(MAP_COLS);
    localparam logic [4:0] ROW_LIM = 5'(MAP_ROWS);

    wr_state_t         state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [4:0]        row_q, row_d;
    logic [5:0]        col_q, col_d;
    tile_t             tile_q, tile_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              wren_q, wren_d;
    logic [4:0]        addr_q, addr_d;
    logic [ROW_W-1:0]  word_q, word_d;
    logic [TILE_W-1:0] old_q, old_d;

    logic [N_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_valid;
    logic [4:0]        sel_row;
    logic [5:0]        sel_col;
    logic [TILE_W-1:0] sel_tile;
    logic              sel_oor;

    rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
        .req_i         (bus.req),
        .last_served_i (last_q),
        .grant_o       (arb_gnt),
        .idx_o         (arb_idx),
        .valid_o       (arb_valid)
    );

    assign sel_row  = bus.req_row[int'(arb_idx)*5 +: 5];
    assign sel_col  = bus.req_col[int'(arb_idx)*6 +: 6];
    assign sel_tile = bus.req_tile[int'(arb_idx)*TILE_W +: TILE_W];
    assign sel_oor  = (sel_col >= COL_LIM) || (sel_row >= ROW_LIM);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        row_d   = row_q;
        col_d   = col_q;
        tile_d  = tile_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        word_d  = word_q;
        old_d   = old_q;
        grant_d = '0;
        done_d  = '0;
        err_d   = 1'b0;
        wren_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable && arb_valid) begin
                    win_d   = arb_idx;
                    row_d   = sel_row;
                    col_d   = sel_col;
                    tile_d  = tile_t'(sel_tile);
                    addr_d  = sel_row;
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    grant_d = arb_gnt;
                    // Out-of-range targets finish immediately without touching the RAM.
                    if (sel_oor) begin
                        done_d  = arb_gnt;
                        err_d   = 1'b1;
                        old_d   = '0;
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == '0) state_d = ST_CAPTURE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_CAPTURE: begin
                word_d = bus.ram_rddata;
                word_d[tile_lsb(col_q) +: TILE_W] = tile_q;
                old_d   = bus.ram_rddata[tile_lsb(col_q) +: TILE_W];
                wren_d  = 1'b1;
                done_d  = N_REQ'(1) << win_q;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                last_d  = win_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(N_REQ - 1);
            win_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            tile_q  <= TILE_EMPTY;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tile_q  <= tile_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            old_q   <= old_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.old_tile   = old_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_wren   = wren_q;
    assign bus.ram_wrdata = word_q;

endmodule

// File: doc/map_write_arbiter.md
# map_write_arbiter

Read-modify-write sequencer and arbiter for the write port (port B) of the 30×40 tile map RAM. It shares the port among N_REQ requesters, for example the pacman mover, the ghost mover and the map re-initialiser. For each request it replaces one 4-bit tile in a 160-bit row and returns the tile it overwrote, which callers use as the collision type. It sits between the sprite/location controllers and the map RAM; display port A is untouched.

## Interface
- N_REQ, 3: number of requesters; requester 0 is served first after reset.
- RD_LAT, 1: cycles from ram_addr driven to ram_rddata valid (1 to 3).
- MAP_COLS, 40: tiles per row.
- MAP_ROWS, 30: rows in the map.

Ports:
- CLOCK_50  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  when low, no new request is accepted; an in-flight operation still completes.
- req  in  N_REQ  level per requester; held high until that requester's done.
- req_row  in  N_REQ×5  target row per requester, packed with requester i in bits [5i+:5].
- req_col  in  N_REQ×6  target column, packed [6i+:6].
- req_tile  in  N_REQ×4  new tile code, packed [4i+:4].
- grant  out  N_REQ  one-hot, one-cycle pulse when a request is accepted.
- done  out  N_REQ  one-hot, one-cycle pulse when the operation finishes.
- old_tile  out  4  previous tile at the target; valid only in the done cycle.
- err  out  1  pulses with done when the target is out of range.
- busy  out  1  high in every state except IDLE.
- ram_addr  out  5  port-B address.
- ram_wren  out  1  port-B write enable.
- ram_wrdata  out  160  port-B write data.
- ram_rddata  in  160  port-B read data.

## Operation
- Tile placement: column c occupies bits [159−4c : 156−4c], so column 0 is at the MSB, matching the display decode.
- States:
  - IDLE: if enable and any req is high, pick the winner round-robin, starting from (last_served+1) mod N_REQ. Latch the winner's row, col and tile. Go to READ.
  - READ: drive ram_addr=row for RD_LAT cycles. grant[winner] is high in the first READ cycle only.
  - CAPTURE: register ram_rddata into word_q. Extract old = word_q nibble at col.
  - WRITE: drive ram_addr=row, ram_wren=1, ram_wrdata=word_q with only the col nibble replaced by tile. done[winner]=1 and old_tile=old in this cycle. Update last_served=winner. Go to IDLE.
- Out-of-range target (col ≥ MAP_COLS or row ≥ MAP_ROWS):
  - Skip READ and CAPTURE and go straight to WRITE.
  - ram_wren stays 0; done and err pulse; old_tile=0.
- Requesters drop req on the edge where they sample done, so IDLE never re-serves a completed request.
- Changes to a requester's req_row/col/tile after grant are ignored, because values are latched.
- The 156 bits outside the target nibble are written back exactly as read.

## Timing
- Accepting request in cycle 0:
  - grant in cycle 1.
  - CAPTURE in cycle RD_LAT+1.
  - ram_wren and done in cycle RD_LAT+2.
  - IDLE in cycle RD_LAT+3, when the next request can be sampled.
- Throughput: one operation per RD_LAT+3 cycles, which is 4 at the default.
- Out-of-range request: done and err in cycle 1; IDLE in cycle 2.
- Reset values: state=IDLE, last_served=N_REQ−1; grant, done, err, busy, ram_wren all 0; ram_addr=0, ram_wrdata=0, old_tile=0.
- Reset mid-operation: the operation is aborted with no write; ram_wren is 0 from the next cycle; done is never issued for it.
- Simultaneous requests: exactly one grant per operation. With all N_REQ requests held, each requester is served once per N_REQ operations.
- enable falling while in READ or CAPTURE: that operation still writes and completes.
- All outputs are registered; there are no combinational paths from req to grant or to ram_*.

## Structure
- Shared package map_pkg (shared with the map writer, location controllers and VGA tile decode):
  - MAP_COLS, MAP_ROWS, TILE_W=4, ROW_W=160.
  - typedef tile_t, an enum of tile codes.
  - Function tile_lsb(col), returning 156−4·col.
- Sub-module rr_arbiter: inputs req, last_served; outputs the one-hot grant and its index, combinational. This module registers the result.

## Test plan
- Single write, RD_LAT=1: requester 1 writes row 5, col 0, tile 4h, RAM row 5 = 1111…h → grant cycle 1; wren cycle 3 with wrdata bits [159:156]=4h and the rest unchanged; done[1] with old_tile=1h.
- Column edge: col 39 writes to bits [3:0] only. col 40 → err=1 and done in cycle 1, no wren, old_tile=0.
- Contention: all three req held continuously → grant order 0,1,2,0,1,2; one operation every 4 cycles; no wren overlap.
- enable low with req pending → no grant. enable raised → grant next cycle. enable dropped during READ → that operation still writes.
- Reset asserted in CAPTURE → no wren, no done; all outputs at reset values next cycle; first post-reset grant goes to requester 0.
- RD_LAT=3: the captured word equals ram_rddata 3 cycles after the address was driven; done in cycle 5.
